// File: rtl/unidade_controle_ula_pkg.sv
// Shared definitions for the accumulator/ALU controller: opcodes, ALU select codes,
// FSM states and the default datapath width (also used by the ALU beside it).
package unidade_controle_ula_pkg;

  localparam int LARGURA_PADRAO = 5;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_CLR = 3'd3;
  localparam logic [2:0] OP_NOP = 3'd4;
  localparam logic [2:0] OP_HLT = 3'd5;

  localparam logic [4:0] TULA_SOMA = 5'd0;
  localparam logic [4:0] TULA_SUB  = 5'd1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPOSTA = 2'd2,
    PARADO   = 2'd3
  } estado_t;

  // Opcodes 6-7 have no meaning; they complete like NOP but flag an error.
  function automatic logic op_ilegal(input logic [2:0] op);
    return op > OP_HLT;
  endfunction

endpackage

// File: rtl/unidade_controle_ula.sv
// Multicycle accumulator sequencer: accepts one command, drives the external ALU,
// waits LAT_ULA cycles for it to settle, captures into the accumulator and responds.
module unidade_controle_ula
  import unidade_controle_ula_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int LAT_ULA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [LARGURA-1:0] cmd_dado,
  output logic [LARGURA-1:0] barramento,
  output logic [4:0]         tula,
  input  logic [LARGURA-1:0] ulaout,
  output logic [LARGURA-1:0] acumulador,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_z,
  output logic               res_n,
  output logic               res_erro,
  output logic [7:0]         conta_ops
);

  localparam logic [3:0] CNT_INI = 4'(LAT_ULA - 1);

  estado_t            estado, prox;
  logic [2:0]         op;
  logic [3:0]         cnt;
  logic               aceita, captura, entrega;
  logic [LARGURA-1:0] acc_novo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox;
  end

  always_comb begin
    prox      = estado;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    aceita    = 1'b0;
    captura   = 1'b0;
    entrega   = 1'b0;
    case (estado)
      OCIOSO: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          aceita = 1'b1;
          prox   = (cmd_op == OP_HLT) ? PARADO : EXECUTA;
        end
      end
      EXECUTA: begin
        if (cnt == 4'd0) begin
          captura = 1'b1;
          prox    = RESPOSTA;
        end
      end
      RESPOSTA: begin
        res_valid = 1'b1;
        if (res_ready) begin
          entrega = 1'b1;
          prox    = OCIOSO;
        end
      end
      PARADO:  prox = PARADO;
      default: prox = OCIOSO;
    endcase
  end

  // LDA and CLR bypass the ALU; only ADD/SUB take its result.
  always_comb begin
    acc_novo = acumulador;
    case (op)
      OP_ADD, OP_SUB: acc_novo = ulaout;
      OP_LDA:         acc_novo = barramento;
      OP_CLR:         acc_novo = '0;
      OP_NOP:         acc_novo = acumulador;
      default:        acc_novo = acumulador;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op         <= OP_LDA;
      cnt        <= 4'd0;
      barramento <= '0;
      tula       <= TULA_SOMA;
      acumulador <= '0;
      res_z      <= 1'b0;
      res_n      <= 1'b0;
      res_erro   <= 1'b0;
      conta_ops  <= 8'd0;
    end else begin
      if (aceita) begin
        op         <= cmd_op;
        barramento <= cmd_dado;
        cnt        <= CNT_INI;
        tula       <= (cmd_op == OP_SUB) ? TULA_SUB : TULA_SOMA;
      end
      if (estado == EXECUTA && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (captura) begin
        acumulador <= acc_novo;
        res_z      <= (acc_novo == '0);
        res_n      <= acc_novo[LARGURA-1];
        res_erro   <= op_ilegal(op);
      end
      if (entrega)
        conta_ops <= conta_ops + 8'd1;
    end
  end

endmodule

// File: tb/tb_unidade_controle_ula.sv
// Directed bench: two controllers (LAT_ULA=1 and 3), each with a behavioural ALU beside it.
module tb_unidade_controle_ula;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // LAT_ULA = 1 instance
  logic       cmd_valid = 0, cmd_ready, res_valid, res_ready = 1, res_z, res_n, res_erro;
  logic [2:0] cmd_op = 0;
  logic [4:0] cmd_dado = 0, barramento, tula, ulaout, acumulador;
  logic [7:0] conta_ops;

  // LAT_ULA = 3 instance
  logic       cmd_valid3 = 0, cmd_ready3, res_valid3, res_ready3 = 1, res_z3, res_n3, res_erro3;
  logic [2:0] cmd_op3 = 0;
  logic [4:0] cmd_dado3 = 0, barramento3, tula3, ulaout3, acumulador3;
  logic [7:0] conta_ops3;

  assign ulaout  = (tula == 5'd1)  ? acumulador  - barramento  : acumulador  + barramento;
  assign ulaout3 = (tula3 == 5'd1) ? acumulador3 - barramento3 : acumulador3 + barramento3;

  unidade_controle_ula #(.LARGURA(5), .LAT_ULA(1)) dut1 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dado(cmd_dado), .barramento(barramento), .tula(tula),
    .ulaout(ulaout), .acumulador(acumulador), .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_n(res_n), .res_erro(res_erro), .conta_ops(conta_ops));

  unidade_controle_ula #(.LARGURA(5), .LAT_ULA(3)) dut3 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_dado(cmd_dado3), .barramento(barramento3), .tula(tula3),
    .ulaout(ulaout3), .acumulador(acumulador3), .res_valid(res_valid3), .res_ready(res_ready3),
    .res_z(res_z3), .res_n(res_n3), .res_erro(res_erro3), .conta_ops(conta_ops3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command to dut1 at a negedge; k counts edges from accept edge to res_valid.
  // hold>0 keeps res_ready low for that many cycles once the response is up.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [4:0] dado,
                        input logic [4:0] e_acc, input logic e_z, input logic e_n,
                        input logic e_err, input int hold);
    int k;
    if (hold > 0) res_ready = 1'b0;
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_dado = dado;
    @(posedge clock); @(negedge clock);
    cmd_valid = 1'b0; cmd_op = 3'd7; cmd_dado = 5'h1f;
    chk({tag, ".barramento"}, barramento, dado);
    chk({tag, ".tula"}, tula, (op == 3'd2) ? 1 : 0);
    k = 1;
    while (!res_valid && k < 20) begin
      @(posedge clock); @(negedge clock); k++;
    end
    chk({tag, ".latency"}, k, 2);
    chk({tag, ".acc"}, acumulador, e_acc);
    chk({tag, ".z"}, res_z, e_z);
    chk({tag, ".n"}, res_n, e_n);
    chk({tag, ".erro"}, res_erro, e_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); @(negedge clock);
      chk({tag, ".hold_valid"}, res_valid, 1);
      chk({tag, ".hold_acc"}, acumulador, e_acc);
      chk({tag, ".hold_ready"}, cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    chk({tag, ".valid_drop"}, res_valid, 0);
  endtask

  initial begin
    int k;
    logic [7:0] c0;
    repeat (2) @(negedge clock);
    chk("rst.acc", acumulador, 0);
    chk("rst.bar", barramento, 0);
    chk("rst.tula", tula, 0);
    chk("rst.valid", res_valid, 0);
    chk("rst.flags", {res_z, res_n, res_erro}, 0);
    chk("rst.conta", conta_ops, 0);
    chk("rst.ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge clock);

    do_cmd("lda7", 3'd0, 5'd7, 5'd7, 0, 0, 0, 0);
    do_cmd("add5", 3'd1, 5'd5, 5'd12, 0, 0, 0, 0);
    chk("conta2", conta_ops, 2);

    do_cmd("lda31", 3'd0, 5'd31, 5'd31, 0, 1, 0, 0);
    do_cmd("add1wrap", 3'd1, 5'd1, 5'd0, 1, 0, 0, 0);
    do_cmd("lda0", 3'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    do_cmd("sub1wrap", 3'd2, 5'd1, 5'd31, 0, 1, 0, 0);

    c0 = conta_ops;
    do_cmd("add3hold", 3'd1, 5'd3, 5'd2, 0, 0, 0, 5);
    chk("conta_hold", conta_ops, c0 + 8'd1);

    do_cmd("lda9", 3'd0, 5'd9, 5'd9, 0, 0, 0, 0);
    do_cmd("illegal6", 3'd6, 5'd3, 5'd9, 0, 0, 1, 0);
    do_cmd("nop", 3'd4, 5'd21, 5'd9, 0, 0, 0, 0);
    do_cmd("clr", 3'd3, 5'd4, 5'd0, 1, 0, 0, 0);
    chk("conta11", conta_ops, 11);

    // HLT: stays parked with cmd_valid held high
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_dado = 5'd2;
    @(posedge clock); @(negedge clock);
    cmd_op = 3'd0;
    for (int i = 0; i < 10; i++) begin
      chk("hlt.ready", cmd_ready, 0);
      chk("hlt.valid", res_valid, 0);
      @(posedge clock); @(negedge clock);
    end
    cmd_valid = 1'b0;
    chk("hlt.conta", conta_ops, 11);
    chk("hlt.acc", acumulador, 0);

    reset = 1'b1; #1;
    chk("rst2.acc", acumulador, 0);
    chk("rst2.conta", conta_ops, 0);
    chk("rst2.ready", cmd_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    do_cmd("lda4", 3'd0, 5'd4, 5'd4, 0, 0, 0, 0);
    chk("conta_after_rst", conta_ops, 1);

    // LAT_ULA=3 controller: latency, then reset in the middle of EXECUTA
    chk("l3.ready", cmd_ready3, 1);
    cmd_valid3 = 1'b1; cmd_op3 = 3'd0; cmd_dado3 = 5'd6;
    @(posedge clock); @(negedge clock);
    cmd_valid3 = 1'b0;
    k = 1;
    while (!res_valid3 && k < 20) begin
      @(posedge clock); @(negedge clock); k++;
    end
    chk("l3.latency", k, 4);
    chk("l3.acc", acumulador3, 6);
    @(posedge clock); @(negedge clock);
    chk("l3.conta", conta_ops3, 1);

    cmd_valid3 = 1'b1; cmd_op3 = 3'd1; cmd_dado3 = 5'd2;
    @(posedge clock); @(negedge clock);
    cmd_valid3 = 1'b0;
    chk("l3.exec_ready", cmd_ready3, 0);
    @(posedge clock); #2;
    reset = 1'b1; #1;
    chk("l3.abort_acc", acumulador3, 0);
    chk("l3.abort_bar", barramento3, 0);
    chk("l3.abort_valid", res_valid3, 0);
    chk("l3.abort_conta", conta_ops3, 0);
    chk("l3.abort_ready", cmd_ready3, 1);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); @(negedge clock);
      chk("l3.no_resp", res_valid3, 0);
    end
    chk("l3.final_acc", acumulador3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_controle_ula.md
Name: unidade_controle_ula

Overview:
- Multicycle sequencer that owns the accumulator register and drives the 5-bit ALU.
- Accepts one command at a time (opcode + operand) over a valid/ready handshake.
- Drives the ALU operand bus and operation select, waits a configurable settle time, then captures the result into the accumulator.
- Returns accumulator plus zero/negative/error flags over a second valid/ready handshake. Sits between the instruction source and the ALU, which is instantiated beside it.

Parameters:
- LARGURA, 5, datapath width of bus, accumulator and ALU result.
- LAT_ULA, 1, cycles spent in EXECUTA before capture; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode: 0 LDA, 1 ADD, 2 SUB, 3 CLR, 4 NOP, 5 HLT, 6-7 illegal.
- cmd_dado  input  LARGURA  operand.
- barramento  output  LARGURA  registered operand to ALU.
- tula  output  5  registered ALU op select: 0 SOMA, 1 SUB.
- ulaout  input  LARGURA  ALU result, combinational from barramento/acumulador/tula.
- acumulador  output  LARGURA  accumulator register, fed to ALU.
- res_valid  output  1  response present.
- res_ready  input  1  response consumer ready.
- res_z  output  1  accumulator == 0 after the operation.
- res_n  output  1  accumulator bit LARGURA-1 after the operation.
- res_erro  output  1  illegal opcode was received.
- conta_ops  output  8  completed-response counter.

Behaviour:
- Reset (async): state OCIOSO; acumulador=0, barramento=0, tula=0, res_valid=0, res_z=0, res_n=0, res_erro=0, conta_ops=0, latency counter=0. Any in-flight command is dropped and no response is produced.
- States: OCIOSO, EXECUTA, RESPOSTA, PARADO.
- OCIOSO:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op, set barramento=cmd_dado, load the latency counter with LAT_ULA-1.
  - Set tula=1 for SUB; set tula=0 for every other opcode.
  - Next state: EXECUTA, or PARADO for HLT.
- EXECUTA:
  - cmd_ready=0. The counter decrements each cycle.
  - On the edge where the counter==0, capture the result and go to RESPOSTA. Total EXECUTA duration is exactly LAT_ULA cycles.
  - Capture per opcode:
    - ADD: acumulador<=ulaout (acumulador+barramento mod 2^LARGURA).
    - SUB: acumulador<=ulaout (acumulador-barramento mod 2^LARGURA).
    - LDA: acumulador<=barramento (ALU bypassed).
    - CLR: acumulador<=0.
    - NOP and illegal opcodes: acumulador unchanged.
  - On the same edge, register res_z and res_n from the new accumulator value, and set res_erro=1 only for opcodes 6-7.
- RESPOSTA:
  - res_valid=1. acumulador, res_z, res_n and res_erro are held stable while res_ready=0.
  - On res_valid&res_ready: conta_ops increments (wraps 255->0) and the state returns to OCIOSO.
  - res_valid drops in the next cycle; no back-to-back acceptance in the same cycle.
- PARADO:
  - cmd_ready=0, res_valid=0. No response is issued for HLT.
  - Held until reset. cmd_valid is ignored.
- Latency: accept edge to res_valid high is LAT_ULA+1 edges. Minimum command period with res_ready tied high is LAT_ULA+2 cycles.
- Arithmetic is unsigned modulo 2^LARGURA with no carry/overflow output; wrap is silent.
- barramento and tula keep their last values outside EXECUTA.
- cmd_op and cmd_dado are sampled only at the accept edge; changes afterwards are ignored.

Decomposition:
- Shared package: opcode constants (OP_LDA..OP_HLT), tula codes (SOMA=0, SUB=1), state encoding, and the LARGURA default (shared with the ALU).
- No sub-module: the latency counter and FSM stay in one module.
- The ALU is instantiated alongside the controller by the parent: acumulador/barramento/tula in, ulaout back.

Test Plan:
- LDA 7, then ADD 5 with res_ready=1, LAT_ULA=1 -> responses acc=7, then acc=12, z=0, n=0; res_valid is 2 cycles after each accept; conta_ops=2.
- LDA 31, ADD 1 -> acc=0, z=1, n=0. LDA 0, SUB 1 -> acc=31, n=1, z=0.
- ADD 3 with res_ready=0 for 5 cycles -> res_valid and acc held constant, cmd_ready=0 throughout; release -> one handshake, conta_ops+1.
- cmd_op=6 after LDA 9 -> res_erro=1, acc=9. Next NOP -> res_erro=0.
- HLT, then cmd_valid held 10 cycles -> cmd_ready=0, no res_valid. Reset pulse -> OCIOSO, acc=0, conta_ops=0, next LDA 4 completes normally.
- LAT_ULA=3: ADD issued, reset asserted mid-EXECUTA (asynchronously, between edges) -> outputs go to reset values immediately, no res_valid ever; acc=0.
